// File: rtl/audio_sample_player.sv
// rtl/audio_sample_player.sv - multi-channel sample playback with shared memory fetch, saturating mixer and PWM output
module audio_sample_player #(
  parameter int DIV    = 3125,
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        trigger,
  input  logic [NUM_CH-1:0]        loop_en,
  input  logic [NUM_CH*ADDR_W-1:0] start_addr,
  input  logic [NUM_CH*ADDR_W-1:0] length,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_data,
  output logic [NUM_CH-1:0]        busy,
  output logic [DATA_W-1:0]        mix_out,
  output logic                     PWM_out
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = DATA_W + $clog2(NUM_CH) + 1;
  localparam logic [DATA_W-1:0]    MID   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [SW-1:0] MID_S = SW'(MID);
  localparam logic signed [SW-1:0] MAX_S = SW'({DATA_W{1'b1}});

  typedef enum logic {IDLE, PLAY} state_t;

  state_t              state    [NUM_CH];
  logic [ADDR_W-1:0]   offset   [NUM_CH];
  logic [ADDR_W-1:0]   start_q  [NUM_CH];
  logic [ADDR_W-1:0]   len_q    [NUM_CH];
  logic [DATA_W-1:0]   sample   [NUM_CH];
  logic [ADDR_W-1:0]   start_in [NUM_CH];
  logic [ADDR_W-1:0]   len_in   [NUM_CH];
  logic [NUM_CH-1:0]   fetch_ok;
  logic [NUM_CH-1:0]   trig_q;
  logic [NUM_CH-1:0]   rise;
  logic [CW-1:0]       tick_cnt;
  logic [CW-1:0]       cnt_nxt;
  logic                tick;
  logic [DATA_W-1:0]   pwm_cnt;
  logic signed [SW-1:0] acc;
  logic [DATA_W-1:0]   mix_sat;

  assign tick    = (tick_cnt == CW'(DIV - 1));
  assign cnt_nxt = tick ? '0 : tick_cnt + 1'b1;
  assign rise    = trigger & ~trig_q;

  always_comb begin
    busy = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      start_in[ch] = start_addr[ch*ADDR_W +: ADDR_W];
      len_in[ch]   = length[ch*ADDR_W +: ADDR_W];
      busy[ch]     = (state[ch] == PLAY);
    end
  end

  // Signed sum of deviations from silence, clamped to the output range.
  always_comb begin
    acc = MID_S;
    for (int ch = 0; ch < NUM_CH; ch++)
      acc = acc + $signed(SW'(sample[ch])) - MID_S;
    if (acc < 0)
      mix_sat = '0;
    else if (acc > MAX_S)
      mix_sat = '1;
    else
      mix_sat = acc[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
      pwm_cnt  <= '0;
      mem_addr <= '0;
      mix_out  <= MID;
      PWM_out  <= 1'b0;
      trig_q   <= '1;  // a trigger must be seen low before its rise counts
      fetch_ok <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        state[ch]   <= IDLE;
        offset[ch]  <= '0;
        start_q[ch] <= '0;
        len_q[ch]   <= '0;
        sample[ch]  <= MID;
      end
    end else begin
      tick_cnt <= cnt_nxt;
      pwm_cnt  <= pwm_cnt + 1'b1;
      PWM_out  <= (pwm_cnt < mix_out);
      trig_q   <= trigger;
      mem_addr <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (cnt_nxt == CW'(ch)) begin
          fetch_ok[ch] <= (state[ch] == PLAY);
          if (state[ch] == PLAY)
            mem_addr <= start_q[ch] + offset[ch];
        end
        if (tick_cnt == CW'(ch + 1))
          sample[ch] <= fetch_ok[ch] ? mem_data : MID;
        // Retrigger takes priority over end-of-clip handling.
        if (rise[ch] && (len_in[ch] != '0)) begin
          start_q[ch] <= start_in[ch];
          len_q[ch]   <= len_in[ch];
          offset[ch]  <= '0;
          state[ch]   <= PLAY;
        end else if ((cnt_nxt == CW'(ch)) && (state[ch] == PLAY)) begin
          if (offset[ch] == len_q[ch] - 1'b1) begin
            offset[ch] <= '0;
            if (!loop_en[ch])
              state[ch] <= IDLE;
          end else begin
            offset[ch] <= offset[ch] + 1'b1;
          end
        end
      end
      if (tick_cnt == CW'(NUM_CH + 1))
        mix_out <= mix_sat;
    end
  end

endmodule

// File: tb/tb_audio_sample_player.sv
// tb/tb_audio_sample_player.sv - directed vector bench for audio_sample_player
module tb_audio_sample_player;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  trigger;
  logic [1:0]  loop_en;
  logic [15:0] start_addr;
  logic [15:0] length;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_data;
  logic [1:0]  busy;
  logic [7:0]  mix_out;
  logic        PWM_out;

  int n_vec = 0;
  int n_err = 0;
  int phase = 0;

  audio_sample_player #(.DIV(16), .NUM_CH(2), .ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .trigger(trigger), .loop_en(loop_en),
    .start_addr(start_addr), .length(length), .mem_addr(mem_addr),
    .mem_data(mem_data), .busy(busy), .mix_out(mix_out), .PWM_out(PWM_out)
  );

  always #5 clk = ~clk;

  // Memory returns its own address one clock later.
  always @(posedge clk) mem_data <= mem_addr;

  // Expected position within the 16-clock sample period.
  always @(posedge clk) begin
    if (reset) phase <= 0;
    else       phase <= (phase == 15) ? 0 : phase + 1;
  end

  typedef struct {
    logic [7:0] s0, s1, l0, l1;
    logic [1:0] trig;
    logic [7:0] exp_mix;
    logic [1:0] exp_busy;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    @(negedge clk);
    while (phase != p && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check("wait_phase_timeout", n, 0);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    trigger = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic trig_pulse(input logic [1:0] m);
    wait_phase(8);
    trigger = m;
    @(negedge clk);
    trigger = 2'b00;
  endtask

  initial begin
    int hi;
    int bad;
    tbl[0] = '{8'hF0, 8'hF0, 8'd4, 8'd4, 2'b11, 8'd255, 2'b11};
    tbl[1] = '{8'h10, 8'h10, 8'd4, 8'd4, 2'b11, 8'd0,   2'b11};
    tbl[2] = '{8'h90, 8'h00, 8'd4, 8'd4, 2'b01, 8'h90,  2'b01};
    tbl[3] = '{8'h00, 8'h40, 8'd4, 8'd4, 2'b10, 8'h40,  2'b10};
    tbl[4] = '{8'h90, 8'h70, 8'd4, 8'd4, 2'b11, 8'd128, 2'b11};
    tbl[5] = '{8'hA0, 8'hC0, 8'd4, 8'd4, 2'b11, 8'd224, 2'b11};
    tbl[6] = '{8'h30, 8'h50, 8'd0, 8'd4, 2'b11, 8'h50,  2'b10};

    loop_en = 2'b00; start_addr = '0; length = '0;
    do_reset();

    // Idle after reset
    repeat (100) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_mix", mix_out, 128);
    check("idle_addr", mem_addr, 0);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (PWM_out) hi++;
    end
    check("pwm_duty", hi, 128);

    // Table of mix / busy vectors
    for (int v = 0; v < 7; v++) begin
      do_reset();
      start_addr = {tbl[v].s1, tbl[v].s0};
      length     = {tbl[v].l1, tbl[v].l0};
      trig_pulse(tbl[v].trig);
      wait_phase(0);
      wait_phase(4);
      check($sformatf("vec%0d_mix", v), mix_out, tbl[v].exp_mix);
      check($sformatf("vec%0d_busy", v), busy, tbl[v].exp_busy);
    end

    // One-shot clip of 3 samples
    do_reset();
    start_addr = {8'h00, 8'h90}; length = {8'h00, 8'd3}; loop_en = 2'b00;
    trig_pulse(2'b01);
    for (int i = 0; i < 3; i++) begin
      wait_phase(0);
      check($sformatf("oneshot_addr%0d", i), mem_addr, 8'h90 + i);
      wait_phase(4);
      check($sformatf("oneshot_mix%0d", i), mix_out, 8'h90 + i);
      check($sformatf("oneshot_busy%0d", i), busy, (i < 2) ? 1 : 0);
    end
    wait_phase(0);
    check("oneshot_addr_end", mem_addr, 0);
    wait_phase(4);
    check("oneshot_mix_end", mix_out, 128);

    // Looping clip
    do_reset();
    loop_en = 2'b01;
    trig_pulse(2'b01);
    for (int i = 0; i < 5; i++) begin
      wait_phase(0);
      check($sformatf("loop_addr%0d", i), mem_addr, 8'h90 + (i % 3));
      check($sformatf("loop_busy%0d", i), busy, 1);
    end
    loop_en = 2'b00;

    // Retrigger at offset 2 of a 5-sample clip
    do_reset();
    start_addr = {8'h00, 8'h20}; length = {8'h00, 8'd5};
    trig_pulse(2'b01);
    wait_phase(0);
    check("retrig_addr0", mem_addr, 8'h20);
    wait_phase(0);
    check("retrig_addr1", mem_addr, 8'h21);
    trig_pulse(2'b01);
    wait_phase(0);
    check("retrig_addr_restart", mem_addr, 8'h20);
    check("retrig_busy", busy, 1);

    // Zero-length trigger is ignored
    do_reset();
    length = {8'h00, 8'h00};
    trig_pulse(2'b01);
    wait_phase(0);
    check("len0_busy", busy, 0);
    check("len0_addr", mem_addr, 0);

    // Reset during playback, trigger held through reset release
    do_reset();
    start_addr = {8'h60, 8'h50}; length = {8'd10, 8'd10};
    trig_pulse(2'b11);
    wait_phase(4);
    check("pre_reset_busy", busy, 3);
    reset = 1'b1;
    trigger = 2'b11;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_mix", mix_out, 128);
    check("abort_addr", mem_addr, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy != 2'b00 || mem_addr != 8'h00) bad++;
    end
    check("held_trigger_no_play", bad, 0);
    trigger = 2'b00;
    repeat (2) @(negedge clk);
    trig_pulse(2'b11);
    wait_phase(0);
    check("after_release_busy", busy, 3);
    check("after_release_addr", mem_addr, 8'h50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
